// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store sequencer between the execute stage and the data-memory port
// One access in flight; errors are answered without touching memory.
module lsu_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_is_store,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [4:0]            sx_op,
  output logic [DATA_WIDTH-1:0] sx_in,
  input  logic [DATA_WIDTH-1:0] sx_result,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Extension selects understood by the signext instance.
  localparam logic [4:0] SX_3100  = 5'd0;
  localparam logic [4:0] SX_0700  = 5'd1;
  localparam logic [4:0] SX_1500  = 5'd2;
  localparam logic [4:0] SXU_0700 = 5'd3;
  localparam logic [4:0] SXU_1500 = 5'd4;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]            state;
  logic [7:0]            cnt;
  logic                  is_store_q;
  logic [1:0]            off_q;
  logic [1:0]            off;
  logic                  accept;
  logic                  f3_legal;
  logic                  misaligned;
  logic [4:0]            op_dec;
  logic [3:0]            be_dec;
  logic [DATA_WIDTH-1:0] wdata_dec;

  assign off       = req_addr[1:0];
  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;
  assign mem_req   = (state == REQ);
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = (rsp_valid && !rsp_err && !is_store_q) ? sx_result : '0;

  always_comb begin
    f3_legal = 1'b0;
    op_dec   = SX_3100;
    case (req_funct3)
      3'b000: begin f3_legal = 1'b1;          op_dec = SX_0700;  end
      3'b001: begin f3_legal = 1'b1;          op_dec = SX_1500;  end
      3'b010: begin f3_legal = 1'b1;          op_dec = SX_3100;  end
      3'b100: begin f3_legal = !req_is_store; op_dec = SXU_0700; end
      3'b101: begin f3_legal = !req_is_store; op_dec = SXU_1500; end
      default: f3_legal = 1'b0;
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    case (req_funct3[1:0])
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = (off != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  // Loads always read the full word; stores replicate data so any lane sees it.
  always_comb begin
    be_dec    = 4'b1111;
    wdata_dec = req_wdata;
    if (req_is_store) begin
      case (req_funct3[1:0])
        2'b00: begin
          be_dec    = 4'b0001 << off;
          wdata_dec = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          be_dec    = 4'b0011 << off;
          wdata_dec = {2{req_wdata[15:0]}};
        end
        default: begin
          be_dec    = 4'b1111;
          wdata_dec = req_wdata;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      is_store_q <= 1'b0;
      off_q      <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      sx_op      <= SX_3100;
      sx_in      <= '0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            is_store_q <= req_is_store;
            off_q      <= off;
            if (f3_legal && !misaligned) begin
              state     <= REQ;
              cnt       <= '0;
              mem_we    <= req_is_store;
              mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
              mem_be    <= be_dec;
              mem_wdata <= wdata_dec;
              rsp_err   <= 1'b0;
              if (!req_is_store) sx_op <= op_dec;
            end else begin
              state   <= RESP;
              rsp_err <= 1'b1;
            end
          end
        end
        REQ: begin
          // An ack on the final allowed cycle still completes successfully.
          if (mem_ack) begin
            state   <= RESP;
            rsp_err <= 1'b0;
            if (!is_store_q) sx_in <= mem_rdata >> {off_q, 3'b000};
          end else if (cnt == CNT_LAST) begin
            state   <= RESP;
            rsp_err <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - self-checking bench for lsu_ctrl
// Transaction model drives per-cycle expectations; a negedge process compares.
module tb_lsu_ctrl;

  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [4:0]  sx_op;
  logic [31:0] sx_in, sx_result;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  int n_checks = 0;
  int n_err    = 0;

  lsu_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .sx_op(sx_op), .sx_in(sx_in), .sx_result(sx_result),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Stand-in for the external signext block.
  always_comb begin
    sx_result = sx_in;
    case (sx_op)
      5'd1:    sx_result = {{24{sx_in[7]}}, sx_in[7:0]};
      5'd2:    sx_result = {{16{sx_in[15]}}, sx_in[15:0]};
      5'd3:    sx_result = {24'h0, sx_in[7:0]};
      5'd4:    sx_result = {16'h0, sx_in[15:0]};
      default: sx_result = sx_in;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] s;
    s = rd >> (8 * a[1:0]);
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b100:  return {24'h0, s[7:0]};
      3'b101:  return {16'h0, s[15:0]};
      default: return s;
    endcase
  endfunction

  function automatic bit access_bad(input logic st, input logic [2:0] f3, input logic [31:0] a);
    bit legal;
    legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (!legal) return 1'b1;
    if (f3[1:0] == 2'd1 && a[0]) return 1'b1;
    if (f3[1:0] == 2'd2 && a[1:0] != 2'd0) return 1'b1;
    return 1'b0;
  endfunction

  logic        chk_en = 1'b0;
  logic        exp_ready = 1'b1, exp_mem_req = 1'b0, exp_rsp_valid = 1'b0, exp_err = 1'b0;
  logic [31:0] exp_rdata = '0;
  logic        e_we = 1'b0;
  logic [31:0] e_addr = '0, e_wdata = '0;
  logic [3:0]  e_be = '0;
  int          req_cyc = 0;
  logic        last_we = 1'b0, last_err = 1'b0;
  logic [3:0]  last_be = '0;
  logic [31:0] last_addr = '0, last_wdata = '0, last_rdata = '0, last_sx_in = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready", req_ready, exp_ready);
      check("mem_req", mem_req, exp_mem_req);
      check("rsp_valid", rsp_valid, exp_rsp_valid);
      if (mem_req === 1'b1) begin
        req_cyc++;
        last_we = mem_we; last_be = mem_be; last_addr = mem_addr; last_wdata = mem_wdata;
      end
      if (exp_mem_req) begin
        check("mem_we", mem_we, e_we);
        check("mem_addr", mem_addr, e_addr);
        check("mem_be", mem_be, e_be);
        check("mem_wdata", mem_wdata, e_wdata);
      end
      if (exp_rsp_valid) begin
        check("rsp_err", rsp_err, exp_err);
        check("rsp_rdata", rsp_rdata, exp_rdata);
        last_err = rsp_err; last_rdata = rsp_rdata; last_sx_in = sx_in;
      end
    end
  end

  // Called and returns at posedge+1. ack_cyc = 0 means memory never acks.
  task automatic do_access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd, input int ack_cyc);
    bit bad, acked;
    int cyc;
    bad    = access_bad(st, f3, a);
    e_we   = st;
    e_addr = {a[31:2], 2'b00};
    e_be   = 4'hF;
    e_wdata = wd;
    if (st && f3 == 3'd0) begin e_be = 4'b0001 << a[1:0]; e_wdata = {4{wd[7:0]}}; end
    if (st && f3 == 3'd1) begin e_be = 4'b0011 << a[1:0]; e_wdata = {2{wd[15:0]}}; end
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_cyc = 0; exp_ready = 1'b0; acked = 1'b0;
    if (bad) begin
      exp_rsp_valid = 1'b1; exp_err = 1'b1; exp_rdata = '0;
    end else begin
      exp_mem_req = 1'b1;
      cyc = 1;
      forever begin
        acked = (cyc == ack_cyc);
        mem_ack = acked;
        mem_rdata = acked ? rd : $urandom;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        if (acked || cyc >= TO) break;
        cyc++;
      end
      exp_mem_req = 1'b0; exp_rsp_valid = 1'b1; exp_err = !acked;
      exp_rdata = (acked && !st) ? load_val(f3, a, rd) : 32'h0;
    end
    @(posedge clk); #1;
    exp_rsp_valid = 1'b0; exp_ready = 1'b1;
  endtask

  initial begin
    #12;
    check("rst_ready", req_ready, 1);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_be", mem_be, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_sx_op", sx_op, 0);
    check("rst_sx_in", sx_in, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    @(posedge clk); #1;
    rst = 1'b0; chk_en = 1'b1;
    @(posedge clk); #1;

    do_access(0, 3'b000, 32'h103, 0, 32'h80FF_1234, 1);
    check("lb_sx_in", last_sx_in, 32'h80);
    check("lb_rdata", last_rdata, 32'hFFFF_FF80);
    do_access(0, 3'b101, 32'h102, 0, 32'h9ABC_0000, 2);
    check("lhu_be", last_be, 4'b1111);
    check("lhu_addr", last_addr, 32'h100);
    check("lhu_rdata", last_rdata, 32'h0000_9ABC);
    check("lhu_err", last_err, 0);
    do_access(1, 3'b001, 32'h202, 32'h1234_5678, 0, 1);
    check("sh_we", last_we, 1);
    check("sh_be", last_be, 4'b1100);
    check("sh_wdata", last_wdata, 32'h5678_5678);
    check("sh_rdata", last_rdata, 0);
    do_access(0, 3'b010, 32'h101, 0, 0, 1);
    check("lw_mis_no_req", req_cyc, 0);
    check("lw_mis_err", last_err, 1);
    do_access(0, 3'b010, 32'h600, 0, 32'h1111_2222, 0);
    check("timeout_req_cycles", req_cyc, TO);
    check("timeout_err", last_err, 1);
    do_access(0, 3'b010, 32'h604, 0, 32'hCAFE_BABE, TO);
    check("last_ack_req_cycles", req_cyc, TO);
    check("last_ack_err", last_err, 0);
    check("last_ack_rdata", last_rdata, 32'hCAFE_BABE);

    do_access(1, 3'b000, 32'h301, 32'h0000_00AB, 0, 3);
    do_access(1, 3'b010, 32'h400, 32'hDEAD_BEEF, 0, 3);
    do_access(0, 3'b001, 32'h102, 0, 32'h8000_0000, 1);
    do_access(0, 3'b100, 32'h101, 0, 32'h0000_F000, 2);
    do_access(0, 3'b011, 32'h100, 0, 0, 1);
    do_access(1, 3'b100, 32'h100, 32'h1, 0, 1);
    do_access(1, 3'b001, 32'h203, 32'h1, 0, 1);
    do_access(0, 3'b001, 32'h101, 0, 0, 1);
    do_access(0, 3'b000, 32'h100, 0, 32'h0000_007F, 1);

    chk_en = 1'b0;
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_addr = 32'h700;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("pre_rst_mem_req", mem_req, 1);
    #3 rst = 1'b1;
    #1;
    check("async_drop_mem_req", mem_req, 0);
    check("async_rst_ready", req_ready, 1);
    repeat (2) begin @(posedge clk); #1; check("rst_no_rsp", rsp_valid, 0); end
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; check("post_rst_no_rsp", rsp_valid, 0); end
    exp_ready = 1'b1; exp_mem_req = 1'b0; exp_rsp_valid = 1'b0;
    chk_en = 1'b1;
    do_access(0, 3'b010, 32'h704, 0, 32'h0BAD_F00D, 2);
    check("post_rst_rdata", last_rdata, 32'h0BAD_F00D);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
